// File: rtl/robot_pkg.sv
// Shared motor command codes, U-turn controller state encoding and small helpers
// used by the drive subsystem.
package robot_pkg;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;
  localparam logic [1:0] MOT_BRK  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    BRAKE_IN,
    SPIN_BLIND,
    SEEK,
    ALIGN,
    BRAKE_OUT,
    WAIT_REL,
    ABORT_BRK
  } uturn_state_t;

  // Returns {left, right} motor codes for an on-the-spot spin; dir=0 spins left.
  function automatic logic [3:0] spin_pattern(input logic dir);
    return dir ? {MOT_FWD, MOT_REV} : {MOT_REV, MOT_FWD};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous sensor inputs; output lags input by two clocks.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uturn_controller.sv
// Owns the motor command bus: passes line-tracker commands through in IDLE and
// runs the brake / blind spin / seek / align / brake U-turn sequence on request.
module uturn_controller
  import robot_pkg::*;
#(
  parameter int BRAKE_CYC   = 50000,
  parameter int BLIND_CYC   = 200000,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 5000000,
  parameter bit SPIN_DIR    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_tracking,
  input  logic       en_uturn,
  input  logic [1:0] track_l,
  input  logic [1:0] track_r,
  input  logic [2:0] line,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       uturn_finished,
  output logic       uturn_fault,
  output logic       busy
);

  localparam int PHASE_MAX = max3(BRAKE_CYC, BLIND_CYC, SETTLE_CYC);
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0] PHASE_TOP  = PW'(PHASE_MAX);
  localparam logic [PW-1:0] BRAKE_END  = PW'(BRAKE_CYC - 1);
  localparam logic [PW-1:0] BLIND_END  = PW'(BLIND_CYC - 1);
  localparam logic [PW-1:0] SETTLE_END = PW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TO_TOP     = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_END     = TW'(TIMEOUT_CYC - 1);

  uturn_state_t  state_q, state_next;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    line_s;
  logic          centre;
  logic          side_unused;
  logic          in_spin;
  logic          timeout_hit;
  logic          timeout_take;
  logic [1:0]    motor_l_d, motor_r_d;
  logic          finished_d, fault_d, busy_d;

  sync_2ff #(.WIDTH(3)) u_line_sync (
    .clk (clk),
    .rst (rst),
    .d   (line),
    .q   (line_s)
  );

  assign centre       = line_s[1];
  assign side_unused  = ^{line_s[2], line_s[0]};
  assign in_spin      = (state_q == SPIN_BLIND) || (state_q == SEEK) || (state_q == ALIGN);
  assign timeout_hit  = (to_cnt == TO_END);
  assign timeout_take = in_spin && en_uturn && timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_next;
  end

  // Abort has priority over timeout, which has priority over normal progress.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:       if (en_uturn) state_next = BRAKE_IN;
      BRAKE_IN: begin
        if (!en_uturn)                   state_next = ABORT_BRK;
        else if (phase_cnt == BRAKE_END) state_next = SPIN_BLIND;
      end
      SPIN_BLIND: begin
        if (!en_uturn)                   state_next = ABORT_BRK;
        else if (timeout_hit)            state_next = BRAKE_OUT;
        else if (phase_cnt == BLIND_END) state_next = SEEK;
      end
      SEEK: begin
        if (!en_uturn)        state_next = ABORT_BRK;
        else if (timeout_hit) state_next = BRAKE_OUT;
        else if (centre)      state_next = ALIGN;
      end
      ALIGN: begin
        if (!en_uturn)                    state_next = ABORT_BRK;
        else if (timeout_hit)             state_next = BRAKE_OUT;
        else if (!centre)                 state_next = SEEK;
        else if (phase_cnt == SETTLE_END) state_next = BRAKE_OUT;
      end
      BRAKE_OUT:  if (phase_cnt == BRAKE_END) state_next = WAIT_REL;
      WAIT_REL:   if (!en_uturn) state_next = IDLE;
      ABORT_BRK:  if (phase_cnt == BRAKE_END) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    motor_l_d  = MOT_STOP;
    motor_r_d  = MOT_STOP;
    busy_d     = (state_next != IDLE);
    finished_d = (state_q == BRAKE_OUT) && (state_next == WAIT_REL);
    fault_d    = uturn_fault;
    case (state_next)
      IDLE: begin
        if (en_tracking) begin
          motor_l_d = track_l;
          motor_r_d = track_r;
        end
      end
      BRAKE_IN, BRAKE_OUT, ABORT_BRK: begin
        motor_l_d = MOT_BRK;
        motor_r_d = MOT_BRK;
      end
      SPIN_BLIND, SEEK, ALIGN: {motor_l_d, motor_r_d} = spin_pattern(SPIN_DIR);
      default: ;
    endcase
    if ((state_q == IDLE) && (state_next == BRAKE_IN)) fault_d = 1'b0;
    if (timeout_take) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      motor_l        <= MOT_STOP;
      motor_r        <= MOT_STOP;
      uturn_finished <= 1'b0;
      uturn_fault    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      motor_l        <= motor_l_d;
      motor_r        <= motor_r_d;
      uturn_finished <= finished_d;
      uturn_fault    <= fault_d;
      busy           <= busy_d;
    end
  end

  // Phase counter restarts on every state change; timeout counter spans the whole spin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      if (state_next != state_q)   phase_cnt <= '0;
      else if (phase_cnt != PHASE_TOP) phase_cnt <= phase_cnt + PW'(1);
      if ((state_next == SPIN_BLIND) && (state_q != SPIN_BLIND)) to_cnt <= '0;
      else if (in_spin && (to_cnt != TO_TOP))                    to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uturn_controller.sv
// Scoreboard bench for uturn_controller: the driver queues the expected registered
// outputs for every clock it issues, and a monitor compares them on the falling edge.
module tb_uturn_controller;

  logic       clk, rst, en_tracking, en_uturn;
  logic [1:0] track_l, track_r, motor_l, motor_r;
  logic [2:0] line;
  logic       uturn_finished, uturn_fault, busy;

  typedef struct {
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  uturn_controller #(
    .BRAKE_CYC   (4),
    .BLIND_CYC   (10),
    .SETTLE_CYC  (3),
    .TIMEOUT_CYC (40),
    .SPIN_DIR    (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en_tracking    (en_tracking),
    .en_uturn       (en_uturn),
    .track_l        (track_l),
    .track_r        (track_r),
    .line           (line),
    .motor_l        (motor_l),
    .motor_r        (motor_r),
    .uturn_finished (uturn_finished),
    .uturn_fault    (uturn_fault),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares the live outputs against an expected {motor_l, motor_r, finished, fault, busy}.
  task automatic checkOutput(input string tag, input logic [6:0] expv);
    logic [6:0] act;
    act = {motor_l, motor_r, uturn_finished, uturn_fault, busy};
    n_checks++;
    if (act === expv) n_pass++;
    else
      $display("[TB] FAIL %s @%0t: got ml=%b mr=%b fin=%b flt=%b busy=%b, expected ml=%b mr=%b fin=%b flt=%b busy=%b",
               tag, $time, act[6:5], act[4:3], act[2], act[1], act[0],
               expv[6:5], expv[4:3], expv[2], expv[1], expv[0]);
  endtask

  // Issues n clock edges with the current inputs, queueing the expected outputs after each.
  task automatic applyStimulus(input string tag, input logic [1:0] ml, input logic [1:0] mr,
                               input logic fin, input logic flt, input logic bsy, input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      e.v   = {ml, mr, fin, flt, bsy};
      e.tag = tag;
      exp_q.push_back(e);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput(e.tag, e.v);
      end
    end
  end

  initial begin : driver
    rst         = 1'b0;
    en_tracking = 1'b0;
    en_uturn    = 1'b0;
    track_l     = 2'b00;
    track_r     = 2'b00;
    line        = 3'b000;
    #2;
    checkOutput("reset_state", 7'b0000000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Tracker passthrough
    applyStimulus("idle_stop", 2'b00, 2'b00, 0, 0, 0, 2);
    en_tracking = 1'b1; track_l = 2'b01; track_r = 2'b10;
    applyStimulus("pass_track", 2'b01, 2'b10, 0, 0, 0, 3);
    en_tracking = 1'b0;
    applyStimulus("pass_off", 2'b00, 2'b00, 0, 0, 0, 2);

    // Normal turn; centre already high during the blind spin
    en_uturn = 1'b1;
    applyStimulus("nt_brake_in", 2'b11, 2'b11, 0, 0, 1, 4);
    line = 3'b010;
    applyStimulus("nt_spin", 2'b10, 2'b01, 0, 0, 1, 14);
    applyStimulus("nt_brake_out", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("nt_finished", 2'b00, 2'b00, 1, 0, 1, 1);
    applyStimulus("nt_wait_rel", 2'b00, 2'b00, 0, 0, 1, 3);
    en_uturn = 1'b0; line = 3'b000;
    applyStimulus("nt_idle", 2'b00, 2'b00, 0, 0, 0, 2);

    // Glitch: one short high run drops back to SEEK before the real alignment
    en_uturn = 1'b1;
    applyStimulus("gl_brake_in", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("gl_spin_a", 2'b10, 2'b01, 0, 0, 1, 11);
    line = 3'b010;
    applyStimulus("gl_spin_b", 2'b10, 2'b01, 0, 0, 1, 2);
    line = 3'b000;
    applyStimulus("gl_spin_c", 2'b10, 2'b01, 0, 0, 1, 1);
    line = 3'b010;
    applyStimulus("gl_spin_d", 2'b10, 2'b01, 0, 0, 1, 4);
    line = 3'b000;
    applyStimulus("gl_spin_e", 2'b10, 2'b01, 0, 0, 1, 1);
    applyStimulus("gl_brake_out", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("gl_finished", 2'b00, 2'b00, 1, 0, 1, 1);
    en_uturn = 1'b0;
    applyStimulus("gl_idle", 2'b00, 2'b00, 0, 0, 0, 2);

    // Timeout: centre never seen
    en_uturn = 1'b1;
    applyStimulus("to_brake_in", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("to_spin", 2'b10, 2'b01, 0, 0, 1, 40);
    applyStimulus("to_brake_out", 2'b11, 2'b11, 0, 1, 1, 4);
    applyStimulus("to_finished", 2'b00, 2'b00, 1, 1, 1, 1);
    applyStimulus("to_wait_rel", 2'b00, 2'b00, 0, 1, 1, 2);
    en_uturn = 1'b0;
    applyStimulus("to_idle_fault", 2'b00, 2'b00, 0, 1, 0, 2);

    // U-turn beats tracking, clears the fault, then is aborted in SEEK
    en_uturn = 1'b1; en_tracking = 1'b1; track_l = 2'b01; track_r = 2'b01;
    applyStimulus("ab_brake_in", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("ab_spin", 2'b10, 2'b01, 0, 0, 1, 11);
    en_uturn = 1'b0;
    applyStimulus("ab_brake", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("ab_idle_track", 2'b01, 2'b01, 0, 0, 0, 2);
    en_tracking = 1'b0;
    applyStimulus("ab_idle_stop", 2'b00, 2'b00, 0, 0, 0, 2);

    // Asynchronous reset in the middle of the blind spin
    en_uturn = 1'b1;
    applyStimulus("ar_brake_in", 2'b11, 2'b11, 0, 0, 1, 4);
    applyStimulus("ar_spin", 2'b10, 2'b01, 0, 0, 1, 3);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("async_reset", 7'b0000000);
    en_uturn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus("ar_after", 2'b00, 2'b00, 0, 0, 0, 3);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uturn_controller.md
Name: uturn_controller

Overview:
Sequences the drive motors for a U-turn when the Core raises en_uturn, and returns uturn_finished when the turn is complete. Owns the motor command bus. It muxes between the line-tracker's commands (when Core asserts en_tracking) and its own internal U-turn sequence. It sits between Core, the line tracker and the motor driver; uturn_finished feeds Core directly.

Parameters:
BRAKE_CYC, 50000, brake duration in cycles before spin and after alignment (>=1)
BLIND_CYC, 200000, spin cycles during which the line sensors are ignored, to leave the current line (>=1)
SETTLE_CYC, 3, consecutive cycles the centre sensor must read high to accept alignment (>=1)
TIMEOUT_CYC, 5000000, maximum cycles from spin start to alignment (>BLIND_CYC)
SPIN_DIR, 0, 0 = spin left (L reverse, R forward); 1 = spin right

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
en_tracking  in  1  Core: pass tracker commands to the motors
en_uturn  in  1  Core: U-turn request (level)
track_l  in  2  tracker left motor command
track_r  in  2  tracker right motor command
line  in  3  line sensors {left, centre, right}, asynchronous, 1 = line seen
motor_l  out  2  left motor command (00 stop, 01 fwd, 10 rev, 11 brake)
motor_r  out  2  right motor command
uturn_finished  out  1  one-cycle pulse: sequence ended (success or timeout)
uturn_fault  out  1  last U-turn timed out; held until the next U-turn starts
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE
  - motor_l = motor_r = 00
  - uturn_finished = 0, uturn_fault = 0, busy = 0
  - counters = 0, synchroniser flops = 0
- Outputs: all registered; motor outputs change 1 cycle after the state or input change that causes them.
- line is synchronised by 2 flops; the FSM sees line changes 2 cycles late.
- Counters:
  - One phase counter, width $clog2(max(BRAKE_CYC, BLIND_CYC, SETTLE_CYC)+1); reset on every state entry.
  - One timeout counter, width $clog2(TIMEOUT_CYC+1); reset on entry to SPIN_BLIND, runs through SPIN_BLIND, SEEK and ALIGN.
  - Neither counter wraps.
- States and transitions:
  - IDLE:
    - Motors = track_l/track_r if en_tracking, else 00.
    - If en_uturn=1, go to BRAKE_IN, clear uturn_fault. en_uturn wins over en_tracking when both are high.
  - BRAKE_IN: motors 11/11 for BRAKE_CYC cycles, then SPIN_BLIND.
  - SPIN_BLIND: spin pattern (SPIN_DIR=0: 10/01; SPIN_DIR=1: 01/10) for BLIND_CYC cycles; line ignored; then SEEK.
  - SEEK: spin; when the synchronised centre sensor = 1, go to ALIGN.
  - ALIGN:
    - Spin continues.
    - Centre sensor = 0 before SETTLE_CYC consecutive high cycles: back to SEEK; settle count restarts.
    - SETTLE_CYC consecutive highs: go to BRAKE_OUT.
  - BRAKE_OUT: 11/11 for BRAKE_CYC cycles. On exit, uturn_finished pulses for exactly 1 cycle; go to WAIT_REL.
  - WAIT_REL: motors 00; go to IDLE once en_uturn=0. A held en_uturn never retriggers.
- Timeout: timeout counter reaches TIMEOUT_CYC in SPIN_BLIND/SEEK/ALIGN → go to BRAKE_OUT and set uturn_fault=1. The finished pulse still fires, so Core never hangs.
- Abort: en_uturn=0 in BRAKE_IN, SPIN_BLIND, SEEK or ALIGN → go to ABORT_BRK.
  - ABORT_BRK: 11/11 for BRAKE_CYC cycles, then IDLE.
  - No finished pulse; uturn_fault unchanged.
- en_uturn dropping during BRAKE_OUT is ignored; the sequence completes normally.
- en_tracking and track_* are ignored in every state except IDLE.
- Reset mid-sequence: motors go to 00 immediately (asynchronously); no pulse is emitted.

Decomposition:
- Package robot_pkg holds:
  - motor codes: MOT_STOP=2'b00, MOT_FWD=2'b01, MOT_REV=2'b10, MOT_BRK=2'b11
  - state enum: IDLE, BRAKE_IN, SPIN_BLIND, SEEK, ALIGN, BRAKE_OUT, WAIT_REL, ABORT_BRK
  - helper function for the spin pattern from SPIN_DIR
- One sub-module, sync_2ff (parameter WIDTH), for the line synchroniser; reusable for other asynchronous sensor inputs.

Test Plan:
All scenarios use BRAKE_CYC=4, BLIND_CYC=10, SETTLE_CYC=3, TIMEOUT_CYC=40, SPIN_DIR=0.
- Passthrough: after reset, outputs = 00/00, 0, 0, 0. en_tracking=1, track_l=01, track_r=10 → motor_l=01, motor_r=10 one cycle later. en_tracking=0 → 00/00 next cycle.
- Normal turn:
  - en_uturn=1 → 11/11 for 4 cycles, then 10/01 for 10 cycles; line=3'b010 held during this blind spin is ignored.
  - Keep centre high → ALIGN; 3 settle cycles → 11/11 for 4 cycles → uturn_finished high exactly 1 cycle, uturn_fault=0.
  - Motors stay 00 while en_uturn stays high; IDLE after en_uturn=0.
- Glitch: in SEEK, centre high 2 cycles, low 1, high 4 → back to SEEK once; finished pulse only after the second high run's 3rd cycle plus brake plus synchroniser latency.
- Timeout: line=000 forever → 40 cycles after SPIN_BLIND entry: 11/11 for 4 cycles, finished pulse, uturn_fault=1. The next en_uturn clears uturn_fault on entry to BRAKE_IN.
- Abort and simultaneity:
  - en_uturn=1 with en_tracking=1 → U-turn wins.
  - en_uturn dropped in SEEK → 11/11 for 4 cycles, IDLE, no finished pulse.
- Async reset: assert rst=0 mid-SPIN_BLIND between clock edges → motors 00 and busy 0 without waiting for a clock edge; after release, IDLE with no pulse.
